// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_stream_reader
//  Purpose  : Streams a contiguous word range out of an external SRAM into a
//             small output FIFO, and presents it over a valid/ready handshake.
//             The block abandons the transfer cleanly when the host reclaims
//             the SRAM.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk        in   system clock
//    nRESET     in   synchronous active-low reset
//    start      in   one-cycle transfer request (sampled only while idle)
//    base_addr  in   first SRAM word address
//    word_cnt   in   number of words to read (0 = immediate done)
//    host_sel   in   1 = host owns the SRAM (aborts a running transfer)
//    SRAM_DIN   in   SRAM read data
//    SRAM_ADDR  out  SRAM address
//    SRAM_nCS   out  chip select, active low
//    SRAM_nOE   out  output enable, active low
//    SRAM_nWE   out  write enable, always 1
//    dout       out  FIFO head word
//    dout_valid out  dout holds a word
//    dout_ready in   consumer accepts dout
//    busy       out  transfer in progress
//    done       out  one-cycle pulse, transfer complete
//    abort      out  one-cycle pulse, transfer killed by host_sel
//    checksum   out  running sum of pushed words (0 when not built)
//
//  Build option
//    SRAM_READ_CHECKSUM_EN : when defined, builds the running checksum.
// ============================================================================
module sram_stream_reader #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int WAIT_CYC   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic              host_sel,
    input  logic [DATA_W-1:0] SRAM_DIN,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_nCS,
    output logic              SRAM_nOE,
    output logic              SRAM_nWE,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [DATA_W-1:0] checksum
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;
    localparam logic [2:0] c_ST_DRAIN   = 3'd5;

    logic [2:0]          state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [ADDR_W-1:0]   remain_q, remain_d;
    logic [c_WAIT_W-1:0] wait_q,   wait_d;
    logic                ncs_q,    ncs_d;
    logic                noe_q,    noe_d;
    logic                nwe_q;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                abort_q,  abort_d;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_q,     wr_d;
    logic [c_PTR_W-1:0]  rd_q,     rd_d;
    logic [c_CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0]   dout_q,   dout_d;
    logic                valid_q,  valid_d;

    logic                push;
    logic                pop;
    logic                flush;
    logic [c_CNT_W-1:0]  occ_after_pop;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wait_d   = wait_q;
        ncs_d    = ncs_q;
        noe_d    = noe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;

        pop           = valid_q && dout_ready;
        occ_after_pop = count_q - c_CNT_W'(pop);

        case (state_q)
            c_ST_IDLE: begin
                if (start && !host_sel) begin
                    if (word_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Strobes and address are registered on entry so
                        // they are already valid during the SETUP cycle.
                        addr_d   = base_addr;
                        remain_d = word_cnt;
                        busy_d   = 1'b1;
                        ncs_d    = 1'b0;
                        noe_d    = 1'b0;
                        state_d  = c_ST_SETUP;
                    end
                end
            end
            c_ST_SETUP: begin
                wait_d  = c_WAIT_W'(WAIT_CYC - 1);
                state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = c_ST_CAPTURE;
                end else begin
                    wait_d = wait_q - c_WAIT_W'(1);
                end
            end
            c_ST_CAPTURE: begin
                push     = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - ADDR_W'(1);
                if (remain_q == ADDR_W'(1)) begin
                    ncs_d   = 1'b1;
                    noe_d   = 1'b1;
                    state_d = c_ST_DRAIN;
                end else if ((occ_after_pop + c_CNT_W'(1)) < c_CNT_W'(FIFO_DEPTH)) begin
                    state_d = c_ST_SETUP;
                end else begin
                    ncs_d   = 1'b1;
                    noe_d   = 1'b1;
                    state_d = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (occ_after_pop < c_CNT_W'(FIFO_DEPTH)) begin
                    ncs_d   = 1'b0;
                    noe_d   = 1'b0;
                    state_d = c_ST_SETUP;
                end
            end
            c_ST_DRAIN: begin
                // Finishing on the edge of the last pop makes done appear
                // exactly one cycle after that pop.
                if (occ_after_pop == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        // Host reclaim wins over everything, including a same-cycle push.
        if ((state_q != c_ST_IDLE) && host_sel) begin
            push    = 1'b0;
            flush   = 1'b1;
            ncs_d   = 1'b1;
            noe_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            abort_d = 1'b1;
            state_d = c_ST_IDLE;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = SRAM_DIN;
        end

        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
            dout_d  = dout_q;
        end else begin
            wr_d    = wr_q + c_PTR_W'(push);
            rd_d    = rd_q + c_PTR_W'(pop);
            count_d = occ_after_pop + c_CNT_W'(push);
            valid_d = (count_d != '0);
            // dout is a register copy of the head: when the FIFO would be
            // empty after the pop, the incoming word becomes the new head.
            if (occ_after_pop == '0) begin
                dout_d = push ? SRAM_DIN : dout_q;
            end else begin
                dout_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q  <= c_ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            wait_q   <= '0;
            ncs_q    <= 1'b1;
            noe_q    <= 1'b1;
            nwe_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wait_q   <= wait_d;
            ncs_q    <= ncs_d;
            noe_q    <= noe_d;
            nwe_q    <= 1'b1;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef SRAM_READ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == c_ST_IDLE) && start && !host_sel) begin
            checksum_d = '0;
        end else if (push) begin
            checksum_d = checksum_q + SRAM_DIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign SRAM_ADDR  = addr_q;
    assign SRAM_nCS   = ncs_q;
    assign SRAM_nOE   = noe_q;
    assign SRAM_nWE   = nwe_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign abort      = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_stream_reader
//  Purpose  : Self-checking bench for sram_stream_reader. The SRAM returns
//             (address[15:0] ^ key); expected words, addresses and checksum
//             are derived from the transfer parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 16;
    localparam int WAIT_CYC   = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              nRESET;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_cnt;
    logic              host_sel;
    logic [DATA_W-1:0] SRAM_DIN;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_nCS;
    logic              SRAM_nOE;
    logic              SRAM_nWE;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
    logic              abort;
    logic [DATA_W-1:0] checksum;

    logic [15:0]       sram_key = 16'h0000;

    sram_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_CYC   (WAIT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .start      (start),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .host_sel   (host_sel),
        .SRAM_DIN   (SRAM_DIN),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_nCS   (SRAM_nCS),
        .SRAM_nOE   (SRAM_nOE),
        .SRAM_nWE   (SRAM_nWE),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // SRAM model: data only when selected and output-enabled.
    assign SRAM_DIN = (!SRAM_nCS && !SRAM_nOE) ? (SRAM_ADDR[15:0] ^ sram_key) : 16'hDEAD;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled away from the active edge.
    logic [15:0]       got[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                done_cnt, abort_cnt, last_pop_cyc, done_cyc, first_valid_cyc;
    bit                valid_seen, ncs_seen, busy_seen;
    bit                prev_ncs = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (dout_valid && dout_ready) begin
            got.push_back(dout);
            last_pop_cyc = cyc;
        end
        if (dout_valid && !valid_seen) begin
            valid_seen      = 1'b1;
            first_valid_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (abort) abort_cnt = abort_cnt + 1;
        if (!SRAM_nCS) begin
            ncs_seen = 1'b1;
            if (prev_ncs || (SRAM_ADDR != prev_addr)) addr_log.push_back(SRAM_ADDR);
        end
        if (busy) busy_seen = 1'b1;
        prev_ncs  = SRAM_nCS;
        prev_addr = SRAM_ADDR;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        got.delete();
        addr_log.delete();
        done_cnt   = 0;
        abort_cnt  = 0;
        valid_seen = 1'b0;
        ncs_seen   = 1'b0;
        busy_seen  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},  SRAM_ADDR,  0);
        check({tag, "_ncs"},   SRAM_nCS,   1);
        check({tag, "_noe"},   SRAM_nOE,   1);
        check({tag, "_nwe"},   SRAM_nWE,   1);
        check({tag, "_dout"},  dout,       0);
        check({tag, "_valid"}, dout_valid, 0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_done"},  done,       0);
        check({tag, "_abort"}, abort,      0);
        check({tag, "_csum"},  checksum,   0);
    endtask

    function automatic logic [15:0] sram_word(input logic [ADDR_W-1:0] a, input logic [15:0] key);
        return a[15:0] ^ key;
    endfunction

    // Checks a completed transfer: words in order, one done pulse one cycle
    // after the last pop, busy low, checksum = sum of all words.
    task automatic check_stream(input string tag, input logic [ADDR_W-1:0] base,
                                input int cnt, input logic [15:0] key);
        logic [ADDR_W-1:0] a;
        logic [15:0]       e;
        logic [15:0]       sum;
        logic [15:0]       exp_sum;
        sum = '0;
        check({tag, "_nwords"}, got.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            a   = base + ADDR_W'(i);
            e   = sram_word(a, key);
            sum = sum + e;
            if (i < got.size()) check($sformatf("%s_w%0d", tag, i), got[i], e);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc - last_pop_cyc, 1);
        check({tag, "_busy_end"}, busy, 0);
`ifdef SRAM_READ_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
        check({tag, "_csum"}, checksum, exp_sum);
    endtask

    task automatic run_xfer(input string tag, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W-1:0] cnt, input logic [15:0] key,
                            input bit rnd_ready, output int first_rel);
        int c0;
        int n;
        clear_logs();
        sram_key   = key;
        base_addr  = base;
        word_cnt   = cnt;
        dout_ready = 1'b1;
        start      = 1'b1;
        c0         = cyc;
        tick();
        start = 1'b0;
        n     = 0;
        while (done_cnt == 0 && n < 500) begin
            if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        dout_ready = 1'b1;
        tick();
        first_rel = first_valid_cyc - c0;
        check_stream(tag, base, int'(cnt), key);
    endtask

    int                fr;
    int                n;
    logic [ADDR_W-1:0] b;
    logic [15:0]       k;

    initial begin
        nRESET     = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_cnt   = '0;
        host_sel   = 1'b0;
        dout_ready = 1'b1;
        clear_logs();
        repeat (3) tick();
        check_reset_state("reset");
        nRESET = 1'b1;
        tick();

        // Basic read with the reference data pattern.
        run_xfer("basic", 18'h00010, 18'd3, 16'hA5A5, 1'b0, fr);
        check("basic_first_valid", fr, 3 + WAIT_CYC);
        check("basic_w0_lit", got.size() > 0 ? got[0] : 16'h0, 16'hA5B5);
`ifdef SRAM_READ_CHECKSUM_EN
        check("basic_csum_lit", checksum, 16'hF120);
`endif

        // Random transfers with a randomly stalling consumer.
        for (int t = 0; t < 4; t++) begin
            run_xfer($sformatf("rnd%0d", t), ADDR_W'($urandom), ADDR_W'($urandom_range(1, 10)),
                     16'($urandom), 1'b1, fr);
        end

        // Backpressure: consumer stalled, FIFO fills after FIFO_DEPTH reads.
        clear_logs();
        b          = ADDR_W'($urandom);
        k          = 16'($urandom);
        sram_key   = k;
        base_addr  = b;
        word_cnt   = 18'd8;
        dout_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("bp_reads", addr_log.size(), FIFO_DEPTH);
        check("bp_ncs",   SRAM_nCS, 1);
        check("bp_noe",   SRAM_nOE, 1);
        check("bp_valid", dout_valid, 1);
        check("bp_head",  dout, sram_word(b, k));
        check("bp_busy",  busy, 1);
        dout_ready = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check_stream("bp", b, 8, k);
        check("bp_total_reads", addr_log.size(), 8);

        // Address wrap at the top of the SRAM.
        run_xfer("wrap", 18'h3FFFE, 18'd4, 16'($urandom), 1'b0, fr);
        check("wrap_nreads", addr_log.size(), 4);
        check("wrap_a0", addr_log.size() > 0 ? addr_log[0] : 18'h15555, 18'h3FFFE);
        check("wrap_a1", addr_log.size() > 1 ? addr_log[1] : 18'h15555, 18'h3FFFF);
        check("wrap_a2", addr_log.size() > 2 ? addr_log[2] : 18'h15555, 18'h00000);
        check("wrap_a3", addr_log.size() > 3 ? addr_log[3] : 18'h15555, 18'h00001);

        // Zero-length request: immediate done, no SRAM access.
        clear_logs();
        base_addr = ADDR_W'($urandom);
        word_cnt  = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done_pulse", done, 1);
        tick();
        check("zero_done_low", done, 0);
        repeat (4) tick();
        check("zero_ncs_never_low", ncs_seen, 0);
        check("zero_busy_never",    busy_seen, 0);
        check("zero_done_cnt",      done_cnt, 1);

        // Abort during WAIT of the second word.
        clear_logs();
        b          = ADDR_W'($urandom);
        k          = 16'($urandom);
        sram_key   = k;
        base_addr  = b;
        word_cnt   = 18'd5;
        dout_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(SRAM_nCS == 1'b0 && SRAM_ADDR == b + ADDR_W'(1)) && n < 50) begin
            tick();
            n++;
        end
        tick();
        host_sel = 1'b1;
        tick();
        host_sel = 1'b0;
        check("abort_ncs",   SRAM_nCS, 1);
        check("abort_noe",   SRAM_nOE, 1);
        check("abort_pulse", abort, 1);
        check("abort_valid", dout_valid, 0);
        check("abort_busy",  busy, 0);
        tick();
        check("abort_pulse_end", abort, 0);
        repeat (3) tick();
        check("abort_cnt",      abort_cnt, 1);
        check("abort_no_done",  done_cnt, 0);
        check("abort_one_word", got.size(), 1);
        run_xfer("post_abort", ADDR_W'($urandom), ADDR_W'($urandom_range(2, 6)), 16'($urandom), 1'b0, fr);

        // Synchronous reset during CAPTURE of the second word.
        clear_logs();
        b          = ADDR_W'($urandom);
        sram_key   = 16'($urandom);
        base_addr  = b;
        word_cnt   = 18'd6;
        dout_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        check_reset_state("midrst");
        dout_ready = 1'b1;
        repeat (5) tick();
        check("midrst_fifo_empty", dout_valid, 0);
        check("midrst_no_pops",    got.size(), 0);
        check("midrst_idle_ncs",   SRAM_nCS, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_stream_reader.md
# sram_stream_reader

Read-side counterpart of the host SRAM loader. Once the host has loaded the external SRAM and released it (`host_sel` low), this block streams a contiguous word range out of SRAM into the processing engine. It drives the SRAM read strobes with a configurable access wait and buffers the words in a small FIFO. Words are handed to the consumer over a valid/ready handshake, and the block aborts cleanly if the host reclaims the SRAM.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM word address width.
- `DATA_W`, 16: SRAM data width.
- `WAIT_CYC`, 2: wait cycles between address setup and data capture (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `nRESET` in 1: synchronous active-low reset, sampled on `clk` rising edge.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `base_addr` in ADDR_W: first word address.
- `word_cnt` in ADDR_W: number of words to read.
- `host_sel` in 1: 1 = host owns the SRAM.
- `SRAM_DIN` in DATA_W: SRAM read data.
- `SRAM_ADDR` out ADDR_W: SRAM address.
- `SRAM_nCS` out 1: chip select, active low.
- `SRAM_nOE` out 1: output enable, active low.
- `SRAM_nWE` out 1: write enable, held 1.
- `dout` out DATA_W: FIFO head word.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: consumer accepts `dout`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse, transfer complete.
- `abort` out 1: one-cycle pulse, transfer killed by `host_sel`.
- `checksum` out DATA_W: see Configuration.

## Operation
- All outputs registered. Reset values: `SRAM_ADDR`=0, `SRAM_nCS`=1, `SRAM_nOE`=1, `SRAM_nWE`=1, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `abort`=0, `checksum`=0. Reset also empties the FIFO and forces IDLE.
- The FSM has six states: IDLE, SETUP, WAIT, CAPTURE, HOLD, DRAIN.
- **IDLE**
  - `start` and `host_sel`=0 and `word_cnt`≠0: latch the address and remaining count, set `busy`, go to SETUP.
  - `start` and `word_cnt`=0: pulse `done` the next cycle. No SRAM access occurs.
  - `start` with `host_sel`=1: ignored.
- **SETUP**
  - Drive `SRAM_ADDR`=current address, `SRAM_nCS`=0, `SRAM_nOE`=0.
  - Go to WAIT.
- **WAIT**
  - Hold the strobes for WAIT_CYC cycles, then go to CAPTURE.
- **CAPTURE**
  - Push `SRAM_DIN` into the FIFO.
  - Address increments modulo 2^ADDR_W, so 0x3FFFF wraps to 0x00000.
  - Remaining count decrements.
  - If remaining is now 0: raise `nCS`/`nOE` and go to DRAIN.
  - Else if a FIFO slot is free: go to SETUP. The strobes stay low.
  - Otherwise: raise the strobes and go to HOLD.
- **HOLD**
  - Strobes stay high.
  - Go to SETUP when a FIFO slot is free.
- **DRAIN**
  - Wait until the FIFO is empty and no pop is pending.
  - Then pulse `done`, clear `busy`, and go to IDLE.
- **Slot rule:** a read is issued only if occupancy after this cycle's push and pop is below FIFO_DEPTH. CAPTURE therefore never finds the FIFO full; overflow is impossible by construction.
- **FIFO behaviour**
  - Pop when `dout_valid && dout_ready`.
  - Push and pop may occur in the same cycle, and occupancy is then unchanged.
  - `dout` holds stable while valid and not ready.
- **Abort:** `host_sel`=1 in any state other than IDLE does the following:
  - Next cycle: `nCS`/`nOE`=1, FIFO flushed, `dout_valid`=0, `abort` pulse, `busy`=0, state IDLE.
  - Abort takes priority over a CAPTURE push in the same cycle.

## Timing
- With `start` sampled at edge 0:
  - SETUP occupies cycle 1.
  - WAIT occupies cycles 2 to 1+WAIT_CYC.
  - CAPTURE occupies cycle 2+WAIT_CYC.
  - `dout_valid` rises in cycle 3+WAIT_CYC, which is cycle 5 at the default setting.
- Steady-state throughput is one word per WAIT_CYC+2 cycles when unthrottled.
- `done` asserts one cycle after the last pop and is high for exactly one cycle.

## Configuration
- `SRAM_READ_CHECKSUM_EN`
  - Defined: `checksum` is a running mod-2^DATA_W sum of every word pushed into the FIFO. It clears on accepted `start` and on reset, and holds after `done`/`abort`.
  - Undefined: the adder is not built and `checksum` is tied to 0.

## Test plan
- **Basic read:** SRAM model returns addr^0xA5A5. Apply base=0x00010, cnt=3, `dout_ready`=1, WAIT_CYC=2. Required: `dout` = 0xA5B5, 0xA5B4, 0xA5B7; first valid in cycle 5; a single `done` pulse. With the macro defined, `checksum`=0xF120.
- **Backpressure:** cnt=8, `dout_ready`=0. Required: exactly 4 reads, then `nCS`=1 in HOLD. Raise ready: the remaining 4 words stream in order, with no loss or duplication.
- **Wrap:** base=0x3FFFE, cnt=4. Required: addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- **Zero length:** cnt=0. Required: `done` the next cycle; `nCS` never low; `busy` stays 0.
- **Abort:** raise `host_sel` during WAIT of word 2. Required: `nCS`/`nOE`=1 next cycle, one `abort` pulse, `dout_valid`=0, `busy`=0. A subsequent `start` with `host_sel`=0 works normally.
- **Reset mid-transfer:** `nRESET`=0 for one edge during CAPTURE. Required: all outputs at their reset values and the FIFO empty.
